// File: rtl/req_fifo_sched_if.sv
// Bundle between the round-robin scheduler, its NUM_Q request FIFOs and the
// downstream request channel. The scheduler uses the master modport.
interface req_fifo_sched_if #(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 64
);
    logic [NUM_Q-1:0]       q_empty;
    logic [NUM_Q-1:0]       q_rd;
    logic [NUM_Q*WIDTH-1:0] q_r_data;
    logic [NUM_Q-1:0]       q_r_data_valid;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [2:0]             out_qid;
    logic                   err;

    modport master (
        input  q_empty,
        input  q_r_data,
        input  q_r_data_valid,
        input  out_ready,
        output q_rd,
        output out_valid,
        output out_data,
        output out_qid,
        output err
    );

    modport slave (
        output q_empty,
        output q_r_data,
        output q_r_data_valid,
        output out_ready,
        input  q_rd,
        input  out_valid,
        input  out_data,
        input  out_qid,
        input  err
    );
endinterface

// File: rtl/req_fifo_sched.sv
// Round-robin scheduler draining NUM_Q synchronous-read FIFOs into one
// valid/ready request channel, with up to MAX_BURST entries per grant.
module req_fifo_sched #(
    parameter int NUM_Q     = 4,
    parameter int WIDTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    req_fifo_sched_if.master   bus
);
    localparam int QW = $clog2(NUM_Q);

    localparam logic [QW-1:0]    LAST_RST   = QW'(NUM_Q - 1);
    localparam logic [QW:0]      NQ_W       = (QW + 1)'(NUM_Q);
    localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [NUM_Q-1:0] ONE_HOT0   = {{(NUM_Q-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT,
        HOLD
    } state_t;

    state_t           state_q;
    logic [QW-1:0]    sel_q;
    logic [QW-1:0]    last_q;
    logic [3:0]       burst_q;
    logic [NUM_Q-1:0] q_rd_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [2:0]       out_qid_q;
    logic             err_q;

    logic [WIDTH-1:0] rdata_arr [NUM_Q];
    logic [NUM_Q-1:0] nonempty;
    logic [NUM_Q-1:0] avail_rot;
    logic             srch_hit;
    logic [QW-1:0]    srch_ofs;
    logic [QW:0]      srch_sum;
    logic [QW-1:0]    srch_idx;

    for (genvar g = 0; g < NUM_Q; g++) begin : g_rdata
        assign rdata_arr[g] = bus.q_r_data[g*WIDTH +: WIDTH];
    end

    // Rotate the request vector so bit 0 is queue last+1; the doubled copy
    // makes the rotation a plain shift and puts last itself at the far end.
    assign nonempty  = ~bus.q_empty;
    assign avail_rot = NUM_Q'({nonempty, nonempty} >> (last_q + 1'b1));

    always_comb begin
        srch_hit = |avail_rot;
        srch_ofs = '0;
        for (int j = NUM_Q - 1; j >= 0; j--) begin
            if (avail_rot[j]) begin
                srch_ofs = QW'(j);
            end
        end
    end

    // Map the rotated offset back to a queue index, modulo NUM_Q.
    assign srch_sum = {1'b0, last_q} + {1'b0, srch_ofs} + {{QW{1'b0}}, 1'b1};
    assign srch_idx = (srch_sum >= NQ_W) ? QW'(srch_sum - NQ_W) : QW'(srch_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= LAST_RST;
            burst_q     <= '0;
            q_rd_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_qid_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (srch_hit) begin
                        sel_q   <= srch_idx;
                        burst_q <= '0;
                        q_rd_q  <= ONE_HOT0 << srch_idx;
                        state_q <= POP;
                    end
                end
                POP: begin
                    q_rd_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.q_r_data_valid[sel_q]) begin
                        out_data_q  <= rdata_arr[sel_q];
                        out_qid_q   <= 3'(sel_q);
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    // q_empty already reflects the pop issued in POP.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!bus.q_empty[sel_q] && (burst_q < BURST_LAST)) begin
                            burst_q <= burst_q + 4'd1;
                            q_rd_q  <= ONE_HOT0 << sel_q;
                            state_q <= POP;
                        end else begin
                            last_q  <= sel_q;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.q_rd      = q_rd_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_qid   = out_qid_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_req_fifo_sched.sv
// Bench for req_fifo_sched: queue-based FIFO models, a round-robin/burst
// order predictor, directed scenarios and randomized drain rounds.
module tb_req_fifo_sched;
    localparam int NQ = 4;
    localparam int W  = 64;
    localparam int MB = 4;

    typedef struct {
        int         qid;
        logic [W-1:0] data;
        int         cyc;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    req_fifo_sched_if #(.NUM_Q(NQ), .WIDTH(W)) bus ();

    req_fifo_sched #(.NUM_Q(NQ), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           nt = 0;
    int           nf = 0;
    int           cyc = 0;
    int           exp_last = NQ - 1;
    bit           drop_valid = 1'b0;
    logic [W-1:0] fq [NQ][$];
    ent_t         got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nt++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < NQ; i++) bus.q_empty[i] = (fq[i].size() == 0);
    endtask

    task automatic push(input int q, input logic [W-1:0] d);
        fq[q].push_back(d);
        upd_empty();
    endtask

    // One clock: FIFO models answer the pop strobe seen during the cycle.
    task automatic tick();
        logic [NQ-1:0] rd;
        rd = bus.q_rd;
        @(posedge clk);
        #1;
        bus.q_r_data_valid = '0;
        for (int i = 0; i < NQ; i++) begin
            if (rd[i] && fq[i].size() > 0) begin
                bus.q_r_data[i*W +: W] = fq[i].pop_front();
                bus.q_r_data_valid[i]  = !drop_valid;
            end
        end
        upd_empty();
        cyc++;
        chk("q_rd_onehot0", 64'($onehot0(bus.q_rd)), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NQ; i++) fq[i].delete();
        bus.q_empty        = '1;
        bus.q_r_data_valid = '0;
        bus.out_ready      = 1'b0;
        drop_valid         = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_last = NQ - 1;
    endtask

    // Drain everything currently queued and compare against the predicted order.
    task automatic drain(input string tag, input int ready_pct, input int budget);
        logic [W-1:0] m [NQ][$];
        ent_t         exp_q[$];
        ent_t         e;
        int           q;
        int           n;
        bit           held;
        logic [W-1:0] hd;
        logic [2:0]   hq;
        for (int i = 0; i < NQ; i++) m[i] = fq[i];
        forever begin
            q = -1;
            for (int k = 1; k <= NQ; k++)
                if (q < 0 && m[(exp_last + k) % NQ].size() > 0) q = (exp_last + k) % NQ;
            if (q < 0) break;
            for (int b = 0; b < MB && m[q].size() > 0; b++) begin
                e.qid  = q;
                e.data = m[q].pop_front();
                e.cyc  = 0;
                exp_q.push_back(e);
            end
            exp_last = q;
        end
        got.delete();
        n    = 0;
        held = 1'b0;
        hd   = '0;
        hq   = '0;
        while (got.size() < exp_q.size() && n < budget) begin
            if (held) begin
                chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
                chk({tag, "_hold_data"}, bus.out_data, hd);
                chk({tag, "_hold_qid"}, 64'(bus.out_qid), 64'(hq));
            end
            if (bus.out_valid) begin
                bus.out_ready = ($urandom_range(99) < ready_pct);
                if (bus.out_ready) begin
                    e.qid  = int'(bus.out_qid);
                    e.data = bus.out_data;
                    e.cyc  = cyc;
                    got.push_back(e);
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = bus.out_data;
                    hq   = bus.out_qid;
                end
            end else begin
                bus.out_ready = (ready_pct >= 100) ? 1'b1 : 1'($urandom_range(1));
                held = 1'b0;
            end
            if (got.size() < exp_q.size()) begin
                tick();
                n++;
            end
        end
        chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
        for (int t = 0; t < 6; t++) begin
            tick();
            chk({tag, "_tail_valid"}, 64'(bus.out_valid), 64'd0);
            chk({tag, "_tail_rd"}, 64'(bus.q_rd), 64'd0);
        end
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({tag, "_qid"}, 64'(got[i].qid), 64'(exp_q[i].qid));
            chk({tag, "_data"}, got[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           exp_d [6];
        logic [W-1:0] a;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        bus.q_r_data = '0;
        do_reset();

        chk("rst_q_rd", 64'(bus.q_rd), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", bus.out_data, 64'd0);
        chk("rst_qid", 64'(bus.out_qid), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);

        // Single entry in queue 2: pop one cycle after detect, valid after three.
        a = {$urandom, $urandom};
        bus.out_ready = 1'b1;
        push(2, a);
        tick();
        chk("t1_rd", 64'(bus.q_rd), 64'b0100);
        chk("t1_valid_pop", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t1_rd_wait", 64'(bus.q_rd), 64'd0);
        chk("t1_valid_wait", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data", bus.out_data, a);
        chk("t1_qid", 64'(bus.out_qid), 64'd2);
        tick();
        chk("t1_done", 64'(bus.out_valid), 64'd0);
        exp_last = 2;
        tick();
        chk("t1_idle_rd", 64'(bus.q_rd), 64'd0);

        // last=2 now, so queue 3 wins over queue 1.
        push(1, {$urandom, $urandom});
        push(3, {$urandom, $urandom});
        drain("t1b", 100, 200);
        chk("t1b_first", 64'((got.size() > 0) ? got[0].qid : -1), 64'd3);
        chk("t1b_second", 64'((got.size() > 1) ? got[1].qid : -1), 64'd1);

        do_reset();
        push(0, {$urandom, $urandom});
        push(1, {$urandom, $urandom});
        push(3, {$urandom, $urandom});
        drain("t2", 100, 200);
        chk("t2_q0", 64'((got.size() > 0) ? got[0].qid : -1), 64'd0);
        chk("t2_q1", 64'((got.size() > 1) ? got[1].qid : -1), 64'd1);
        chk("t2_q2", 64'((got.size() > 2) ? got[2].qid : -1), 64'd3);

        // Burst: six in queue 1, one in queue 2.
        for (int i = 0; i < 6; i++) push(1, {$urandom, $urandom});
        push(2, {$urandom, $urandom});
        drain("t3", 100, 300);
        chk("t3_n", 64'(got.size()), 64'd7);
        chk("t3_q4", 64'((got.size() > 3) ? got[3].qid : -1), 64'd1);
        chk("t3_q5", 64'((got.size() > 4) ? got[4].qid : -1), 64'd2);
        chk("t3_q6", 64'((got.size() > 5) ? got[5].qid : -1), 64'd1);
        exp_d = '{3, 3, 3, 4, 4, 3};
        for (int i = 0; i < 6; i++)
            chk("t3_spacing", 64'((got.size() > i + 1) ? got[i+1].cyc - got[i].cyc : -1), 64'(exp_d[i]));

        // Backpressure for ten cycles in HOLD.
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        bus.out_ready = 1'b0;
        push(0, d0);
        push(0, d1);
        tick();
        tick();
        tick();
        chk("t4_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_data", bus.out_data, d0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t4_hold_data", bus.out_data, d0);
            chk("t4_hold_qid", 64'(bus.out_qid), 64'd0);
            chk("t4_hold_rd", 64'(bus.q_rd), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("t4_accept", 64'(bus.out_valid), 64'd0);
        chk("t4_burst_rd", 64'(bus.q_rd), 64'b0001);
        tick();
        tick();
        chk("t4_second_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_second_data", bus.out_data, d1);
        tick();
        chk("t4_end", 64'(bus.out_valid), 64'd0);
        exp_last = 0;

        // Read data never shows up: sticky error, last unchanged.
        drop_valid = 1'b1;
        push(3, {$urandom, $urandom});
        tick();
        chk("t5_rd", 64'(bus.q_rd), 64'b1000);
        tick();
        chk("t5_err_wait", 64'(bus.err), 64'd0);
        tick();
        chk("t5_err", 64'(bus.err), 64'd1);
        chk("t5_valid", 64'(bus.out_valid), 64'd0);
        drop_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_err_sticky", 64'(bus.err), 64'd1);
            chk("t5_idle_valid", 64'(bus.out_valid), 64'd0);
        end
        push(0, {$urandom, $urandom});
        push(2, {$urandom, $urandom});
        drain("t5b", 100, 200);
        chk("t5b_first", 64'((got.size() > 0) ? got[0].qid : -1), 64'd2);
        chk("t5_err_keep", 64'(bus.err), 64'd1);
        do_reset();
        chk("t5_err_clr", 64'(bus.err), 64'd0);

        // Reset while HOLD presents an entry: it is dropped, queue 0 first afterwards.
        push(2, {$urandom, $urandom});
        tick();
        tick();
        tick();
        chk("t6_valid", 64'(bus.out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_async_rd", 64'(bus.q_rd), 64'd0);
        chk("t6_async_data", bus.out_data, 64'd0);
        for (int i = 0; i < NQ; i++) fq[i].delete();
        push(3, {$urandom, $urandom});
        push(0, {$urandom, $urandom});
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_last = NQ - 1;
        drain("t6", 100, 200);
        chk("t6_first", 64'((got.size() > 0) ? got[0].qid : -1), 64'd0);

        // Randomized rounds with random backpressure.
        for (int r = 0; r < 20; r++) begin
            for (int q = 0; q < NQ; q++) begin
                int cnt;
                cnt = $urandom_range(0, 6);
                for (int k = 0; k < cnt; k++) push(q, {$urandom, $urandom});
            end
            drain("rnd", $urandom_range(30, 100), 2000);
        end

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule

// File: doc/req_fifo_sched.md
# req_fifo_sched

Round-robin scheduler that drains NUM_Q request FIFOs into one downstream request channel. Each FIFO has a synchronous read: data and valid arrive one cycle after rd. The scheduler pops one entry at a time from the granted FIFO and presents it downstream on a valid/ready handshake. It allows a bounded burst per grant, so one queue can move back-to-back entries without starving the others.

## Interface
- NUM_Q, 4, number of request FIFOs (2..8)
- WIDTH, 64, request word width
- MAX_BURST, 4, max consecutive entries forwarded per grant (1..15)
- clk  input  1  single clock domain
- reset  input  1  asynchronous, active-high reset
- q_empty  input  NUM_Q  per-FIFO empty flag (registered in FIFO)
- q_rd  output  NUM_Q  per-FIFO pop strobe, at most one bit set
- q_r_data  input  NUM_Q*WIDTH  per-FIFO read data, queue i at bits [i*WIDTH +: WIDTH]
- q_r_data_valid  input  NUM_Q  per-FIFO read-data valid, one cycle after q_rd
- out_valid  output  1  downstream request valid
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  forwarded request word
- out_qid  output  3  source queue index of out_data
- err  output  1  sticky protocol error: pop returned no data

## Operation
- State register values: IDLE, POP, WAIT, HOLD. Registers: sel (granted queue), last (last granted queue), burst (0..MAX_BURST-1).
- IDLE:
  - Search for a non-empty queue, starting at last+1 and wrapping modulo NUM_Q. last itself is searched last.
  - If one is found: sel<=found, burst<=0, go to POP. If none is found: stay in IDLE.
- POP: q_rd[sel]=1 for exactly this cycle; go to WAIT. All other q_rd bits are 0 in every state.
- WAIT:
  - If q_r_data_valid[sel]=1: out_data<=q_r_data[sel], out_qid<=sel, out_valid<=1, go to HOLD.
  - Otherwise: err<=1, go to IDLE, and last is left unchanged.
- HOLD: out_valid, out_data and out_qid are held stable until out_ready=1. On the handshake cycle (out_valid & out_ready):
  - out_valid<=0.
  - If q_empty[sel]=0 and burst<MAX_BURST-1: burst<=burst+1, go to POP with the same sel.
  - Otherwise: last<=sel, go to IDLE.
- q_empty[sel] in HOLD already reflects the pop, because the FIFO flag updates one cycle after rd.
- out_qid is zero-extended from clog2(NUM_Q) bits.
- err is cleared only by reset.

## Timing
- Reset values: state=IDLE, q_rd=0, out_valid=0, out_data=0, out_qid=0, err=0, sel=0, burst=0, last=NUM_Q-1 (queue 0 is checked first after reset).
- Reset assertion at any point aborts the transaction. An entry already popped but not yet accepted is dropped, and the bench must expect this.
- q_rd is a decode of registered state and sel; it never depends combinationally on any input.
- Latency from q_empty falling (scheduler in IDLE) to out_valid rising: 3 cycles (IDLE→POP→WAIT→HOLD).
- Burst throughput with out_ready held at 1: one entry every 3 cycles (HOLD→POP→WAIT→HOLD).
- out_ready high while out_valid is low is ignored.
- Queues becoming non-empty during POP, WAIT or HOLD are not considered until the next IDLE.
- Wrap-around: with last=NUM_Q-1, the search order is 0,1,…,NUM_Q-1.
- Burst counter: never exceeds MAX_BURST-1. With MAX_BURST=1, every handshake returns to IDLE.

## Test plan
- Reset, then push A into queue 2 only (out_ready=1). Expect:
  - q_rd=4'b0100 for one cycle, 1 cycle after the IDLE detect.
  - out_valid 3 cycles after detect, with out_data=A and out_qid=2.
  - Then IDLE with last=2.
- Queues 0,1,3 each hold 1 entry, out_ready=1. Expect out_qid sequence 0,1,3, then back to IDLE with no further q_rd.
- Queue 1 holds 6 entries, queue 2 holds 1, MAX_BURST=4. Expect:
  - out_qid order 1,1,1,1,2,1,1.
  - Entries 2–4 of each burst 3 cycles apart, with no IDLE cycle between them.
- Hold out_ready=0 for 10 cycles in HOLD. Expect:
  - out_valid, out_data and out_qid stable.
  - No q_rd asserted.
  - Advance only on the cycle out_ready=1.
- Force q_r_data_valid low in WAIT. Expect err=1 (sticky), out_valid stays 0, return to IDLE; assert reset and expect err=0.
- Assert reset in HOLD while out_valid=1. Expect asynchronously: out_valid=0 and q_rd=0, with IDLE on release and queue 0 searched first.
